// File: rtl/rk8e_pkg.sv
// Shared types and helpers for the RK8-E sector engine: FSM states, sizes,
// 12-bit word <-> byte-pair mapping and controller status bit positions.
package rk8e_pkg;

    localparam int WORDS_DEF      = 256;
    localparam int HALF_WORDS_DEF = 128;

    // Status register bit positions (PDP-8 numbering, bit 0 = MSB).
    localparam int ST_WRITE_LOCK  = 7;
    localparam int ST_DATA_LATE   = 9;
    localparam int ST_DRIVE_ERROR = 10;

    typedef logic [0:11] pdp_word_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_FETCH,
        S_TX_HI,
        S_TX_LO,
        S_RX_HI,
        S_RX_LO,
        S_STORE,
        S_WAIT_DONE,
        S_FINISH
    } state_e;

    function automatic logic [7:0] pack_hi(input pdp_word_t w);
        return {4'b0000, w[0:3]};
    endfunction

    function automatic logic [7:0] pack_lo(input pdp_word_t w);
        return w[4:11];
    endfunction

    function automatic pdp_word_t unpack(input logic [3:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/rk8e_word_packer.sv
// Holds the word in flight: splits it into hi/lo bytes for the card, or
// assembles it from a received byte pair for memory.
module rk8e_word_packer
    import rk8e_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [0:11] word_i,
    input  logic        rx_hi_i,
    input  logic        rx_lo_i,
    input  logic [7:0]  rx_byte_i,
    input  logic        lo_sel_i,
    output logic [7:0]  tx_byte_o,
    output logic [0:11] word_o
);

    logic [0:11] word_q, word_d;
    logic [3:0]  hi_q, hi_d;

    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        word_d = word_q;
        hi_d   = hi_q;
        if (load_i)  word_d = word_i;
        // Only the low nibble of the high byte carries data.
        if (rx_hi_i) hi_d = rx_byte_i[3:0];
        if (rx_lo_i) word_d = unpack(hi_q, rx_byte_i);
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            hi_q   <= '0;
        end else begin
            word_q <= word_d;
            hi_q   <= hi_d;
        end
    end

    assign tx_byte_o = lo_sel_i ? pack_lo(word_q) : pack_hi(word_q);
    assign word_o    = word_q;

endmodule

// File: rtl/rk8e_sector_engine.sv
// RK8-E disk-side responder: moves one sector between PDP-8 memory
// (data-break cycles) and one 512-byte SD block.
module rk8e_sector_engine
    import rk8e_pkg::*;
#(
    parameter int WORDS      = WORDS_DEF,
    parameter int HALF_WORDS = HALF_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_half,
    input  logic [14:0] cmd_block,
    input  logic [14:0] cmd_addr,
    output logic        db_req,
    output logic        db_we,
    output logic [14:0] db_addr,
    output logic [0:11] db_wdata,
    input  logic [0:11] db_rdata,
    input  logic        db_ack,
    output logic        sd_start,
    output logic        sd_write,
    output logic [31:0] sd_block,
    output logic [7:0]  sd_tx_data,
    output logic        sd_tx_valid,
    input  logic        sd_tx_ready,
    input  logic [7:0]  sd_rx_data,
    input  logic        sd_rx_valid,
    input  logic        sd_done,
    input  logic        sd_error,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [8:0] WORDS_C = 9'(WORDS);
    localparam logic [8:0] HALF_C  = 9'(HALF_WORDS);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic        half_q, half_d;
    logic [14:0] block_q, block_d;
    logic [14:0] addr_q, addr_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        error_q, error_d;

    logic        pk_load, pk_rx_hi, pk_rx_lo;
    logic [0:11] pk_word;
    logic [14:0] addr_inc;
    logic [8:0]  cnt_inc;
    logic        in_xfer;

    // Only the 12-bit address wraps; the field bits are carried unchanged.
    assign addr_inc = {addr_q[14:12], addr_q[11:0] + 12'd1};
    assign cnt_inc  = cnt_q + 9'd1;
    assign in_xfer  = state_q inside {S_START, S_FETCH, S_TX_HI, S_TX_LO,
                                      S_RX_HI, S_RX_LO, S_STORE};

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        half_d   = half_q;
        block_d  = block_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        error_d  = error_q;
        pk_load  = 1'b0;
        pk_word  = '0;
        pk_rx_hi = 1'b0;
        pk_rx_lo = 1'b0;

        case (state_q)
            S_IDLE: if (cmd_valid) begin
                write_d = cmd_write;
                half_d  = cmd_half;
                block_d = cmd_block;
                addr_d  = cmd_addr;
                cnt_d   = '0;
                error_d = 1'b0;
                state_d = S_START;
            end
            S_START: state_d = write_q ? S_FETCH : S_RX_HI;
            S_FETCH: if (db_ack) begin
                pk_load = 1'b1;
                pk_word = db_rdata;
                addr_d  = addr_inc;
                state_d = S_TX_HI;
            end
            S_TX_HI: if (sd_tx_ready) state_d = S_TX_LO;
            S_TX_LO: if (sd_tx_ready) begin
                cnt_d = cnt_inc;
                if (cnt_inc == WORDS_C) begin
                    state_d = S_WAIT_DONE;
                end else if (half_q && cnt_inc >= HALF_C) begin
                    pk_load = 1'b1;
                    state_d = S_TX_HI;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_RX_HI: if (sd_rx_valid) begin
                pk_rx_hi = 1'b1;
                state_d  = S_RX_LO;
            end
            S_RX_LO: if (sd_rx_valid) begin
                pk_rx_lo = 1'b1;
                if (half_q && cnt_q >= HALF_C) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == WORDS_C) ? S_WAIT_DONE : S_RX_HI;
                end else begin
                    state_d = S_STORE;
                end
            end
            S_STORE: if (sd_rx_valid) begin
                error_d = 1'b1;
                state_d = S_FINISH;
            end else if (db_ack) begin
                cnt_d   = cnt_inc;
                addr_d  = addr_inc;
                state_d = (cnt_inc == WORDS_C) ? S_WAIT_DONE : S_RX_HI;
            end
            S_WAIT_DONE: if (sd_done) state_d = S_FINISH;
            S_FINISH:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        // Card errors and premature completion override whatever the data path chose.
        if (state_q != S_IDLE && sd_error) error_d = 1'b1;
        if (in_xfer && (sd_error || sd_done)) begin
            error_d = 1'b1;
            state_d = S_FINISH;
        end
        if (state_q == S_WAIT_DONE && sd_error) state_d = S_FINISH;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            half_q  <= 1'b0;
            block_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            half_q  <= half_d;
            block_q <= block_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    rk8e_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (pk_load),
        .word_i    (pk_word),
        .rx_hi_i   (pk_rx_hi),
        .rx_lo_i   (pk_rx_lo),
        .rx_byte_i (sd_rx_data),
        .lo_sel_i  (state_q == S_TX_LO),
        .tx_byte_o (sd_tx_data),
        .word_o    (db_wdata)
    );

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done        = (state_q == S_FINISH);
    assign error       = error_q;
    assign sd_start    = (state_q == S_START);
    assign sd_write    = write_q;
    assign sd_block    = {17'd0, block_q};
    assign db_req      = (state_q == S_FETCH) || (state_q == S_STORE);
    assign db_we       = (state_q == S_STORE);
    assign db_addr     = addr_q;
    assign sd_tx_valid = (state_q == S_TX_HI) || (state_q == S_TX_LO);

endmodule

// File: tb/tb_rk8e_sector_engine.sv
// Directed bench for rk8e_sector_engine: the sequence plays controller,
// data-break memory and SD driver, comparing against hand-derived values.
module tb_rk8e_sector_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_half;
    logic [14:0] cmd_block, cmd_addr, db_addr;
    logic        db_req, db_we, db_ack;
    logic [0:11] db_wdata, db_rdata;
    logic        sd_start, sd_write;
    logic [31:0] sd_block;
    logic [7:0]  sd_tx_data, sd_rx_data;
    logic        sd_tx_valid, sd_tx_ready, sd_rx_valid, sd_done, sd_error;
    logic        busy, done, error;

    rk8e_sector_engine dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_half(cmd_half), .cmd_block(cmd_block), .cmd_addr(cmd_addr),
        .db_req(db_req), .db_we(db_we), .db_addr(db_addr), .db_wdata(db_wdata),
        .db_rdata(db_rdata), .db_ack(db_ack),
        .sd_start(sd_start), .sd_write(sd_write), .sd_block(sd_block),
        .sd_tx_data(sd_tx_data), .sd_tx_valid(sd_tx_valid), .sd_tx_ready(sd_tx_ready),
        .sd_rx_data(sd_rx_data), .sd_rx_valid(sd_rx_valid),
        .sd_done(sd_done), .sd_error(sd_error),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [14:0] rd_addr [0:511];
    logic [14:0] wr_addr [0:511];
    logic [0:11] wr_data [0:511];
    logic [7:0]  tx_log  [0:1023];
    int          n_rd, n_wr, n_tx, n_rx;
    logic [7:0]  rx_hi_b, rx_lo_b;
    int          inject_after_tx;
    int          start_cnt, start_cyc, first_req_cyc, err_cyc, done_cyc, req_after_ack;
    logic        start_write, err_at_done, busy_at_done, req_after_err, timed_out;
    logic [31:0] start_block;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic half, input logic [14:0] blk,
                         input logic [14:0] addr);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_half  = half;
        cmd_block = blk;
        cmd_addr  = addr;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Plays memory and SD driver cycle by cycle until done or the cycle budget runs out.
    task automatic run_xfer(input logic is_write);
        int  req_cycles = 0;
        int  last_rx    = 0;
        int  done_delay = -1;
        bit  fin        = 0;
        bit  injected   = 0;
        bit  prev_ack   = 0;
        n_rd = 0; n_wr = 0; n_tx = 0; n_rx = 0;
        start_cnt = 0; start_cyc = -100; first_req_cyc = -1; err_cyc = -100; done_cyc = -1;
        req_after_ack = 0; req_after_err = 1'b0; timed_out = 1'b1;
        err_at_done = 1'bx; busy_at_done = 1'bx;
        for (int c = 0; c < 6000 && !fin; c++) begin
            @(negedge clk);
            db_ack = 1'b0; sd_tx_ready = 1'b0; sd_rx_valid = 1'b0;
            sd_done = 1'b0; sd_error = 1'b0;
            if (prev_ack && db_req) req_after_ack++;
            prev_ack = 1'b0;
            if (injected && c == err_cyc + 1) req_after_err = db_req;
            if (done) begin
                done_cyc = c; err_at_done = error; busy_at_done = busy;
                fin = 1; timed_out = 1'b0;
            end
            if (sd_start) begin
                start_cnt++; start_cyc = c; start_write = sd_write;
                start_block = sd_block; last_rx = c;
            end
            if (db_req) begin
                if (first_req_cyc < 0) first_req_cyc = c;
                req_cycles++;
                if (inject_after_tx >= 0 && !injected && n_tx == inject_after_tx) begin
                    sd_error = 1'b1; injected = 1; err_cyc = c;
                end else if (req_cycles == 2) begin
                    db_ack = 1'b1; prev_ack = 1; req_cycles = 0;
                    if (db_we) begin
                        if (n_wr < 512) begin wr_addr[n_wr] = db_addr; wr_data[n_wr] = db_wdata; end
                        n_wr++;
                    end else begin
                        if (n_rd < 512) rd_addr[n_rd] = db_addr;
                        db_rdata = 12'(n_rd);
                        n_rd++;
                    end
                end
            end else begin
                req_cycles = 0;
            end
            if (sd_tx_valid && (c % 3 != 0)) begin
                sd_tx_ready = 1'b1;
                if (n_tx < 1024) tx_log[n_tx] = sd_tx_data;
                n_tx++;
            end
            if (!is_write && start_cnt > 0 && n_rx < 512 && c - last_rx >= 4) begin
                sd_rx_valid = 1'b1;
                sd_rx_data  = n_rx[0] ? rx_lo_b : rx_hi_b;
                n_rx++;
                last_rx = c;
            end
            if (done_delay < 0 && ((is_write && n_tx == 512) || (!is_write && n_rx == 512)))
                done_delay = 6;
            else if (done_delay > 0) begin
                done_delay--;
                if (done_delay == 0) sd_done = 1'b1;
            end
        end
    endtask

    task automatic post_done(input string tag);
        check({tag, "_timeout"}, timed_out, 1'b0);
        check({tag, "_starts"}, start_cnt, 1);
        check({tag, "_busy_at_done"}, busy_at_done, 1'b0);
        check({tag, "_req_after_ack"}, req_after_ack, 0);
        @(negedge clk);
        check({tag, "_done_once"}, {done, cmd_ready, busy}, 3'b010);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_half = 0; cmd_block = 0; cmd_addr = 0;
        db_ack = 0; db_rdata = 0; sd_tx_ready = 0; sd_rx_data = 0; sd_rx_valid = 0;
        sd_done = 0; sd_error = 0; inject_after_tx = -1; rx_hi_b = 0; rx_lo_b = 0;
        repeat (2) @(negedge clk);
        check("reset_ctl", {cmd_ready, busy, done, error, db_req, db_we, sd_start, sd_write, sd_tx_valid},
              9'b1_0000_0000);
        check("reset_data", {sd_block, db_addr, db_wdata, sd_tx_data}, 64'd0);
        reset = 1'b0;

        // Full write: memory word i holds i.
        issue(1'b1, 1'b0, 15'h0012, 15'o10000);
        run_xfer(1'b1);
        check("fw_block", start_block, 32'h0000_0012);
        check("fw_dir", start_write, 1'b1);
        check("fw_req_latency", first_req_cyc - start_cyc, 1);
        check("fw_nrd", n_rd, 256);
        for (int i = 0; i < 256; i++) begin
            int e0 = errors;
            check("fw_addr", rd_addr[i], 15'o10000 + i);
            if (errors != e0) break;
        end
        check("fw_ntx", n_tx, 512);
        for (int i = 0; i < 256; i++) begin
            int e0 = errors;
            check("fw_bytes", {tx_log[2*i], tx_log[2*i+1]}, {8'h00, 8'(i)});
            if (errors != e0) break;
        end
        check("fw_err", err_at_done, 1'b0);
        post_done("fw");

        // Full read: 0A,BC -> 0o5274.
        rx_hi_b = 8'h0A; rx_lo_b = 8'hBC;
        issue(1'b0, 1'b0, 15'h0034, 15'o00200);
        run_xfer(1'b0);
        check("fr_block", start_block, 32'h0000_0034);
        check("fr_dir", start_write, 1'b0);
        check("fr_nwr", n_wr, 256);
        for (int i = 0; i < 256; i++) begin
            int e0 = errors;
            check("fr_word", {wr_addr[i], wr_data[i]}, {15'(15'o00200 + i), 12'o5274});
            if (errors != e0) break;
        end
        check("fr_err", err_at_done, 1'b0);
        post_done("fr");

        // Half write: 128 fetches, second half of the block is zero.
        issue(1'b1, 1'b1, 15'h0005, 15'o10000);
        run_xfer(1'b1);
        check("hw_nrd", n_rd, 128);
        check("hw_ntx", n_tx, 512);
        for (int i = 0; i < 256; i++) begin
            int e0 = errors;
            check("hw_bytes", {tx_log[2*i], tx_log[2*i+1]}, {8'h00, 8'(i < 128 ? i : 0)});
            if (errors != e0) break;
        end
        check("hw_err", err_at_done, 1'b0);
        post_done("hw");

        // Address wrap: field 2 stays, 7777 -> 0000; 01,23 -> 0o0443.
        rx_hi_b = 8'h01; rx_lo_b = 8'h23;
        issue(1'b0, 1'b0, 15'h0040, 15'o27770);
        run_xfer(1'b0);
        check("aw_nwr", n_wr, 256);
        for (int i = 0; i < 256; i++) begin
            int e0 = errors;
            check("aw_word", {wr_addr[i], wr_data[i]},
                  {3'd2, 12'((12'o7770 + i) & 12'o7777), 12'o0443});
            if (errors != e0) break;
        end
        check("aw_err", err_at_done, 1'b0);
        post_done("aw");

        // sd_error after 40 written bytes, while the next fetch is pending.
        inject_after_tx = 40;
        issue(1'b1, 1'b0, 15'h0007, 15'o30000);
        run_xfer(1'b1);
        inject_after_tx = -1;
        check("er_req_drop", req_after_err, 1'b0);
        check("er_done_latency", (done_cyc - err_cyc) inside {[1:2]}, 1'b1);
        check("er_err_at_done", err_at_done, 1'b1);
        check("er_nrd", n_rd, 20);
        post_done("er");
        check("er_sticky", error, 1'b1);

        // Half read clears error on acceptance; F5,6A -> 0o2552, top nibble ignored.
        rx_hi_b = 8'hF5; rx_lo_b = 8'h6A;
        issue(1'b0, 1'b1, 15'h0100, 15'o00400);
        check("hr_err_clear", error, 1'b0);
        run_xfer(1'b0);
        check("hr_nwr", n_wr, 128);
        check("hr_nrx", n_rx, 512);
        for (int i = 0; i < 128; i++) begin
            int e0 = errors;
            check("hr_word", {wr_addr[i], wr_data[i]}, {15'(15'o00400 + i), 12'o2552});
            if (errors != e0) break;
        end
        check("hr_err", err_at_done, 1'b0);
        post_done("hr");

        // Reset while db_req is high.
        issue(1'b1, 1'b0, 15'h0012, 15'o10000);
        for (int i = 0; i < 8 && !db_req; i++) @(negedge clk);
        check("rs_req_seen", db_req, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("rs_ctl", {cmd_ready, busy, done, error, db_req, db_we, sd_start, sd_write, sd_tx_valid},
              9'b1_0000_0000);
        check("rs_data", {sd_block, db_addr, db_wdata, sd_tx_data}, 64'd0);
        reset = 1'b0;
        issue(1'b1, 1'b0, 15'h0012, 15'o10000);
        run_xfer(1'b1);
        check("rs_nrd", n_rd, 256);
        check("rs_ntx", n_tx, 512);
        check("rs_err", err_at_done, 1'b0);
        post_done("rs");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
